// File: rtl/vga_timing.sv
// vga_timing: free-running VGA raster timing generator (pixel clock domain).
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds the frame_cnt output.
module vga_timing #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       hsync,
    output logic       vsync,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    // 11-bit constants so a 1024-wide region bound is representable
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    localparam logic        SYNC_ON = (SYNC_ACTIVE != 0);

    logic [9:0]  nh;
    logic [9:0]  nv;
    logic [10:0] nh_w;
    logic [10:0] nv_w;
    logic [9:0]  nh_nxt;
    logic [9:0]  nv_nxt;
    logic        de_nxt;
    logic        hs_nxt;
    logic        vs_nxt;
    logic        at_origin;

    assign nh_w = {1'b0, nh};
    assign nv_w = {1'b0, nv};

    // Region decode of the next pixel and counter advance
    always_comb begin
        de_nxt    = (nh_w < H_ACT) && (nv_w < V_ACT);
        hs_nxt    = (nh_w >= HS_BEG && nh_w < HS_END) ? SYNC_ON : ~SYNC_ON;
        vs_nxt    = (nv_w >= VS_BEG && nv_w < VS_END) ? SYNC_ON : ~SYNC_ON;
        at_origin = (nh == 10'd0) && (nv == 10'd0);
        nh_nxt    = nh + 10'd1;
        nv_nxt    = nv;
        if (nh_w == H_LAST) begin
            nh_nxt = 10'd0;
            nv_nxt = (nv_w == V_LAST) ? 10'd0 : nv + 10'd1;
        end
    end

    // Present the next pixel on the outputs, then advance the raster
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            nh          <= 10'd0;
            nv          <= 10'd0;
            x           <= 10'd0;
            y           <= 10'd0;
            de          <= 1'b0;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (en) begin
            x           <= nh;
            y           <= nv;
            de          <= de_nxt;
            hsync       <= hs_nxt;
            vsync       <= vs_nxt;
            line_start  <= (nh == 10'd0);
            frame_start <= at_origin;
            nh          <= nh_nxt;
            nv          <= nv_nxt;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic started;

    // Count completed frames; the first frame after reset does not count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= 8'd0;
            started   <= 1'b0;
        end else if (en && at_origin) begin
            if (started) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            started <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing over three parameter sets.
// Define VGA_TIMING_FRAME_CNT_EN to also check frame_cnt over 257 frames.
module tb_vga_timing;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef VGA_TIMING_FRAME_CNT_EN
    localparam bit FC_EN = 1'b1;
`else
    localparam bit FC_EN = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    typedef struct packed {
        logic [1:0] id;
        exp_t       e;
    } sb_t;

    logic [2:0] en    = 3'b000;
    logic [2:0] rst_n = 3'b000;

    logic       hs_a, vs_a, de_a, ls_a, fs_a;
    logic       hs_b, vs_b, de_b, ls_b, fs_b;
    logic       hs_c, vs_c, de_c, ls_c, fs_c;
    logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
    logic [7:0] fc_a, fc_b, fc_c;

    vga_timing dut_a (
        .clk(clk), .rst_n(rst_n[0]), .en(en[0]),
        .hsync(hs_a), .vsync(vs_a), .de(de_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    vga_timing #(
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_n[1]), .en(en[1]),
        .hsync(hs_b), .vsync(vs_b), .de(de_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    vga_timing #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .SYNC_ACTIVE(1)
    ) dut_c (
        .clk(clk), .rst_n(rst_n[2]), .en(en[2]),
        .hsync(hs_c), .vsync(vs_c), .de(de_c), .x(x_c), .y(y_c),
        .line_start(ls_c), .frame_start(fs_c)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_c)
`endif
    );

`ifndef VGA_TIMING_FRAME_CNT_EN
    assign fc_a = 8'd0;
    assign fc_b = 8'd0;
    assign fc_c = 8'd0;
`endif

    // Per-instance geometry for the reference model
    int p_ha [3] = '{640, 640, 8};
    int p_hf [3] = '{16, 16, 2};
    int p_hs [3] = '{96, 96, 3};
    int p_ht [3] = '{800, 800, 14};
    int p_va [3] = '{480, 6, 4};
    int p_vf [3] = '{10, 2, 1};
    int p_vs [3] = '{2, 2, 1};
    int p_vt [3] = '{525, 12, 7};
    bit p_sa [3] = '{1'b0, 1'b0, 1'b1};

    int   m_nh [3];
    int   m_nv [3];
    bit   m_st [3];
    exp_t m_out [3];

    sb_t q[$];
    sb_t s_m;
    int  tests = 0;
    int  fails = 0;

    task automatic chk(input string nm, input int a, input int e);
        tests++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    function automatic exp_t act(input int id);
        exp_t r;
        case (id)
            0: r = '{x_a, y_a, de_a, hs_a, vs_a, ls_a, fs_a, fc_a};
            1: r = '{x_b, y_b, de_b, hs_b, vs_b, ls_b, fs_b, fc_b};
            default: r = '{x_c, y_c, de_c, hs_c, vs_c, ls_c, fs_c, fc_c};
        endcase
        return r;
    endfunction

    // Monitor: every presented edge is compared against the scoreboard
    always @(negedge clk) begin
        if (q.size() > 0) begin
            s_m = q.pop_front();
            tests++;
            if (act(int'(s_m.id)) !== s_m.e) begin
                fails++;
                $display("FAIL sb_dut%0d: got %h expected %h",
                         s_m.id, act(int'(s_m.id)), s_m.e);
            end
        end
    end

    // Drive one edge on instance id, model it, push the expectation
    task automatic cyc(input int id, input bit e, input bit r);
        exp_t o;
        int   h;
        int   v;
        bit   sa;
        sb_t  s;
        en[id]    = e;
        rst_n[id] = r;
        sa = p_sa[id];
        o  = m_out[id];
        if (!r) begin
            m_nh[id] = 0;
            m_nv[id] = 0;
            m_st[id] = 1'b0;
            o = '{10'd0, 10'd0, 1'b0, ~sa, ~sa, 1'b0, 1'b0, 8'd0};
        end else if (e) begin
            h = m_nh[id];
            v = m_nv[id];
            o.x  = 10'(h);
            o.y  = 10'(v);
            o.de = (h < p_ha[id]) && (v < p_va[id]);
            o.hs = (h >= p_ha[id] + p_hf[id] &&
                    h < p_ha[id] + p_hf[id] + p_hs[id]) ? sa : ~sa;
            o.vs = (v >= p_va[id] + p_vf[id] &&
                    v < p_va[id] + p_vf[id] + p_vs[id]) ? sa : ~sa;
            o.ls = (h == 0);
            o.fs = (h == 0) && (v == 0);
            if (o.fs && FC_EN) begin
                if (m_st[id]) o.fc = o.fc + 8'd1;
                m_st[id] = 1'b1;
            end
            h++;
            if (h == p_ht[id]) begin
                h = 0;
                v++;
                if (v == p_vt[id]) v = 0;
            end
            m_nh[id] = h;
            m_nv[id] = v;
        end
        m_out[id] = o;
        s.id = 2'(id);
        s.e  = o;
        q.push_back(s);
        @(negedge clk);
        #2;
    endtask

    initial begin
        int first_hs;
        int last_hs;
        int cnt_hs;
        int prev_ls;
        int first_fs;
        int vs_low;
        int bad_de;
        int de_hi;
        int n_c;
        int fi;
        int prev_fs;
        int hs_in;
        int hs_out;
        int vs_in;
        int vs_out;
        bit prev_vs;

        @(negedge clk);
        #2;

        // Default geometry: reset, first lines, hsync window, mid-frame reset
        cyc(0, 1'b0, 1'b0);
        cyc(0, 1'b0, 1'b0);
        chk("rst_x", int'(x_a), 0);
        chk("rst_de", int'(de_a), 0);
        chk("rst_hs", int'(hs_a), 1);
        chk("rst_vs", int'(vs_a), 1);
        chk("rst_fs", int'(fs_a), 0);
        first_hs = -1;
        last_hs  = -1;
        cnt_hs   = 0;
        prev_ls  = 0;
        for (int k = 1; k <= 1901; k++) begin
            cyc(0, 1'b1, 1'b1);
            if (k == 1) begin
                chk("e1_x", int'(x_a), 0);
                chk("e1_y", int'(y_a), 0);
                chk("e1_de", int'(de_a), 1);
                chk("e1_fs", int'(fs_a), 1);
            end
            if (k == 641) begin
                chk("e641_x", int'(x_a), 640);
                chk("e641_de", int'(de_a), 0);
            end
            if (y_a == 10'd0 && !hs_a) begin
                if (first_hs < 0) first_hs = int'(x_a);
                last_hs = int'(x_a);
                cnt_hs++;
            end
            if (ls_a) begin
                if (prev_ls > 0) chk("ls_period", k - prev_ls, 800);
                prev_ls = k;
            end
        end
        chk("hs_first", first_hs, 656);
        chk("hs_last", last_hs, 751);
        chk("hs_width", cnt_hs, 96);
        chk("pre_rst_x", int'(x_a), 300);
        chk("pre_rst_y", int'(y_a), 2);
        cyc(0, 1'b1, 1'b0);
        chk("midrst_x", int'(x_a), 0);
        chk("midrst_y", int'(y_a), 0);
        chk("midrst_de", int'(de_a), 0);
        chk("midrst_ls", int'(ls_a), 0);
        chk("midrst_hs", int'(hs_a), 1);
        cyc(0, 1'b1, 1'b1);
        chk("post_rst_x", int'(x_a), 0);
        chk("post_rst_y", int'(y_a), 0);
        chk("post_rst_fs", int'(fs_a), 1);
        en[0] = 1'b0;

        // 800x12 raster: vsync, de, frame period, stall at last pixel
        cyc(1, 1'b0, 1'b0);
        first_fs = 0;
        vs_low   = 0;
        bad_de   = 0;
        de_hi    = 0;
        prev_vs  = 1'b1;
        for (int k = 1; k <= 19200; k++) begin
            cyc(1, 1'b1, 1'b1);
            if (fs_b) begin
                if (first_fs > 0) chk("frame_period", k - first_fs, 9600);
                else first_fs = k;
            end
            if (k <= 9600) begin
                if (!vs_b) vs_low++;
                if (de_b) de_hi++;
                if (de_b && y_b >= 10'd6) bad_de++;
                if (prev_vs && !vs_b) begin
                    chk("vs_fall_x", int'(x_b), 0);
                    chk("vs_fall_y", int'(y_b), 8);
                end
            end
            prev_vs = vs_b;
        end
        chk("vs_low_cycles", vs_low, 1600);
        chk("de_count", de_hi, 3840);
        chk("de_blank", bad_de, 0);
        chk("pre_stall_x", int'(x_b), 799);
        chk("pre_stall_y", int'(y_b), 11);
        for (int k = 0; k < 37; k++) begin
            cyc(1, 1'b0, 1'b1);
            if (x_b != 10'd799 || y_b != 10'd11) begin
                chk("stall_hold_xy", int'(x_b) * 1024 + int'(y_b),
                    799 * 1024 + 11);
            end
        end
        chk("stall_end_x", int'(x_b), 799);
        cyc(1, 1'b1, 1'b1);
        chk("wrap_x", int'(x_b), 0);
        chk("wrap_y", int'(y_b), 0);
        chk("wrap_fs", int'(fs_b), 1);
        en[1] = 1'b0;

        // Small active-high geometry, optionally 257 frames of frame_cnt
        cyc(2, 1'b0, 1'b0);
        chk("c_rst_hs", int'(hs_c), 0);
        chk("c_rst_vs", int'(vs_c), 0);
        n_c     = FC_EN ? 256 * 98 + 1 : 2 * 98 + 1;
        fi      = 0;
        prev_fs = 0;
        hs_in   = 0;
        hs_out  = 0;
        vs_in   = 0;
        vs_out  = 0;
        for (int k = 1; k <= n_c; k++) begin
            cyc(2, 1'b1, 1'b1);
            if (fs_c) begin
                if (FC_EN) chk("frame_cnt", int'(fc_c), fi % 256);
                if (prev_fs > 0) chk("c_period", k - prev_fs, 98);
                prev_fs = k;
                fi++;
            end
            if (k <= 98) begin
                if (hs_c && x_c >= 10'd10 && x_c <= 10'd12) hs_in++;
                if (hs_c && (x_c < 10'd10 || x_c > 10'd12)) hs_out++;
                if (vs_c && y_c == 10'd5) vs_in++;
                if (vs_c && y_c != 10'd5) vs_out++;
            end
        end
        chk("c_hs_in", hs_in, 21);
        chk("c_hs_out", hs_out, 0);
        chk("c_vs_in", vs_in, 14);
        chk("c_vs_out", vs_out, 0);
        chk("c_frames", fi, FC_EN ? 257 : 3);
        chk("sb_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running VGA raster timing generator for the 25.2 MHz pixel clock domain. It counts pixels and lines and produces the registered sync, data-enable and coordinate signals that the pixel pipeline and output pins consume. The default parameters give 640x480@60 (800x525 total). A clock-qualify input stalls the raster while the pixel clock is not yet trustworthy.

## Interface
Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vsync width, in lines
- V_BP, 33: vertical back porch, in lines
- SYNC_ACTIVE, 0: asserted level of hsync/vsync (0 = active-low)

Ports:
- clk  in  1  pixel clock; all logic on its rising edge
- rst_n  in  1  reset; synchronous, active-low
- en  in  1  advance enable (tie to PLL lock); low freezes the raster
- hsync  out  1  horizontal sync, level per SYNC_ACTIVE
- vsync  out  1  vertical sync, level per SYNC_ACTIVE
- de  out  1  high when the presented pixel is in the active area
- x  out  10  horizontal position of the presented pixel, 0..H_TOTAL-1
- y  out  10  vertical position of the presented pixel, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse while the presented pixel has x==0
- frame_start  out  1  one-cycle pulse while the presented pixel is (0,0)
- frame_cnt  out  8  completed-frame counter (only with VGA_TIMING_FRAME_CNT_EN)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Both totals must be ≤1024. Elaboration fails if either is larger.
- Internal next-pixel counters nh and nv. All outputs are registers loaded from nh/nv.
- On each clk edge with en=1, the outputs present pixel (nh,nv), then the counters advance:
  - nh wraps from H_TOTAL-1 to 0.
  - When nh wraps, nv increments, wrapping from V_TOTAL-1 to 0.
- Region decode for the presented pixel (x,y):
  - de = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hsync = SYNC_ACTIVE when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_ACTIVE
  - vsync = SYNC_ACTIVE when V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_ACTIVE
  - vsync therefore changes only on pixels with x==0.
- line_start = (x==0); frame_start = (x==0 && y==0).
- While en=0, every output and counter holds its value. A pulse output that is high stays high for the whole stall; the sink qualifies pulses with en.
- Reset (rst_n=0 at an edge) takes priority over en:
  - nh=nv=0; x=y=0; de=0; hsync=vsync=~SYNC_ACTIVE; line_start=frame_start=0; frame_cnt=0.
  - Reset asserted mid-frame aborts the frame; the sequence always restarts at (0,0).

## Timing
- Latency: the first en=1 edge after reset release presents (0,0) with de=1, line_start=1, frame_start=1.
- One pixel is presented per en=1 cycle; the frame period is H_TOTAL*V_TOTAL enabled cycles (420000 at defaults).
- All outputs are registered: no combinational path from en or rst_n to any output.
- x and y always change together on the same edge. Outputs never glitch mid-cycle.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - the frame_cnt port exists;
  - frame_cnt increments modulo 256 on the same edge that presents frame_start=1, except the first frame after reset, so it reads 0 throughout frame 0 and 1 throughout frame 1;
  - frame_cnt holds while en=0 and resets to 0.
- Not defined: the frame_cnt port and its register are absent, and all other behaviour is identical.

## Test plan
- Reset, then en=1 continuously. Response:
  - enabled edge 1 presents x=0,y=0,de=1,frame_start=1;
  - edge 641 presents x=640,de=0;
  - hsync=0 exactly for x=656..751;
  - line_start repeats every 800 edges.
- Run one full frame. Response:
  - vsync=0 exactly for y=490..491, asserting on the edge that presents x=0,y=490;
  - de=0 for all y≥480;
  - the next frame_start comes 420000 edges after the first.
- Toggle en low for 37 cycles at x=799,y=524. Response:
  - outputs hold x=799,y=524 for the whole stall;
  - the next enabled edge presents x=0,y=0,frame_start=1.
- Assert rst_n=0 for 1 cycle at x=300,y=200. Response:
  - the next edge shows all reset values;
  - the first enabled edge after release presents (0,0).
- Instance with SYNC_ACTIVE=1, H_ACTIVE=8,H_FP=2,H_SYNC=3,H_BP=1, V_ACTIVE=4,V_FP=1,V_SYNC=1,V_BP=1. Response:
  - hsync=1 exactly for x=10..12;
  - vsync=1 exactly for y=5;
  - frame period is 98 edges.
- With VGA_TIMING_FRAME_CNT_EN, run 257 frames. Response: frame_cnt reads 0,1,…,255,0 at successive frame_start pulses.
